// File: rtl/cvbs_bt656_decoder.sv
// rtl/cvbs_bt656_decoder.sv - BT.656 byte stream to YC word decoder; define BT656_XY_CHECK_EN to enable XY protection checking
module cvbs_bt656_decoder #(
  parameter logic [11:0] MAX_CNT = 12'd4095
) (
  input  logic        vin_clk,
  input  logic        rst_n,
  input  logic [7:0]  bt656_data,
  output logic        vout_vs,
  output logic        vout_f,
  output logic        vout_de,
  output logic [15:0] vout_data,
  output logic [11:0] vout_width,
  output logic [11:0] vout_height,
  output logic        xy_err
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    PRE1   = 2'd1,
    PRE2   = 2'd2,
    XY     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  d0;
  logic        active;
  logic        phase;
  logic [7:0]  c_lat;
  logic [11:0] word_cnt;
  logic [11:0] line_cnt;
  logic        xy_ok;
  logic        xy_bad;
  logic        xy_f, xy_v, xy_h;

  // Register the incoming byte; everything downstream decodes d0
  always_ff @(posedge vin_clk) begin
    if (!rst_n) d0 <= 8'h00;
    else        d0 <= bt656_data;
  end

  // Reference-code search state register
  always_ff @(posedge vin_clk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // Walk the FF 00 00 XY preamble; an FF anywhere re-arms the search
  always_comb begin
    state_nxt = SEARCH;
    case (state)
      SEARCH:  state_nxt = SEARCH;
      PRE1:    state_nxt = (d0 == 8'h00) ? PRE2 : SEARCH;
      PRE2:    state_nxt = (d0 == 8'h00) ? XY : SEARCH;
      XY:      state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    if (d0 == 8'hFF) state_nxt = PRE1;
  end

  // Classify the byte in the XY slot as an accepted or rejected timing code
  always_comb begin
    xy_f = d0[6];
    xy_v = d0[5];
    xy_h = d0[4];
`ifdef BT656_XY_CHECK_EN
    xy_ok  = (state == XY) && d0[7] &&
             (d0[3] == (xy_v ^ xy_h)) && (d0[2] == (xy_f ^ xy_h)) &&
             (d0[1] == (xy_f ^ xy_v)) && (d0[0] == (xy_f ^ xy_v ^ xy_h));
    xy_bad = (state == XY) && !xy_ok;
`else
    xy_ok  = (state == XY);
    xy_bad = 1'b0;
`endif
  end

  // Video pairing, timing flags and line/field measurement
  always_ff @(posedge vin_clk) begin
    if (!rst_n) begin
      active      <= 1'b0;
      phase       <= 1'b0;
      c_lat       <= 8'h00;
      word_cnt    <= 12'd0;
      line_cnt    <= 12'd0;
      vout_vs     <= 1'b0;
      vout_f      <= 1'b0;
      vout_de     <= 1'b0;
      vout_data   <= 16'h0000;
      vout_width  <= 12'd0;
      vout_height <= 12'd0;
      xy_err      <= 1'b0;
    end else begin
      vout_de <= 1'b0;
      xy_err  <= xy_bad;

      if (active) begin
        if (!phase) begin
          // An FF where a chroma byte belongs is the start of EAV, never video
          if (d0 == 8'hFF) begin
            active <= 1'b0;
          end else begin
            c_lat <= d0;
            phase <= 1'b1;
          end
        end else begin
          vout_data <= {d0, c_lat};
          vout_de   <= 1'b1;
          phase     <= 1'b0;
          if (word_cnt != MAX_CNT) word_cnt <= word_cnt + 12'd1;
        end
      end

      if (xy_ok) begin
        vout_f  <= xy_f;
        vout_vs <= xy_v;
        if (!xy_h) begin
          // SAV: a repeated SAV simply restarts the line without measuring it
          active   <= !xy_v;
          phase    <= 1'b0;
          word_cnt <= 12'd0;
        end else begin
          // EAV: the word counter is cleared so blanking EAVs count no lines
          active   <= 1'b0;
          word_cnt <= 12'd0;
          if (word_cnt != 12'd0) begin
            vout_width <= word_cnt;
            if (line_cnt != MAX_CNT) line_cnt <= line_cnt + 12'd1;
          end
        end
        if (xy_v && !vout_vs && (line_cnt != 12'd0)) begin
          vout_height <= line_cnt;
          line_cnt    <= 12'd0;
        end
      end
    end
  end

endmodule
